// File: rtl/cnnip_mem_if.sv
// Memory port bundle shared by the CNN IP blocks: word-addressed by byte
// address, byte write enables, one-cycle read latency on dout.
interface cnnip_mem_if;
    logic        en;
    logic [3:0]  we;
    logic [15:0] addr;
    logic [31:0] din;
    logic [31:0] dout;

    modport master (output en, output we, output addr, output din, input dout);
    modport slave  (input en, input we, input addr, input din, output dout);
endinterface

// File: rtl/cnnip_conv_engine.sv
// cnnip_conv_engine: full 2-D convolution streamed straight out of the input and
// weight memories through one signed MAC; one accumulated word per output pixel
// per kernel is written to the feature memory.
module cnnip_conv_engine #(
    parameter int          IMG_W   = 32,
    parameter int          DATA_W  = 16,
    parameter int          ACC_W   = 32,
    parameter int          MAX_K   = 7,
    parameter logic [15:0] IN_BASE = 16'h1000,
    parameter logic [15:0] W_BASE  = 16'h2000,
    parameter logic [15:0] F_BASE  = 16'h3000
) (
    input  logic        clk_a,
    input  logic        arstz_aq,
    cnnip_mem_if.master to_input_mem,
    cnnip_mem_if.master to_weight_mem,
    cnnip_mem_if.master to_feature_mem,
    input  logic        CMD_START,
    input  logic [7:0]  MODE_KERNEL_SIZE,
    input  logic [7:0]  MODE_KERNEL_NUMS,
    input  logic [1:0]  MODE_STRIDE,
    input  logic        MODE_PADDING,
    output logic        CMD_DONE,
    output logic        CMD_DONE_VALID,
    output logic        CMD_ERR,
    output logic        BUSY
);

    typedef enum logic [2:0] {ST_IDLE, ST_CHECK, ST_ISSUE, ST_DRAIN, ST_WRITE, ST_DONE} state_t;

    localparam logic [15:0]        IMG_W16 = 16'(IMG_W);
    localparam logic signed [15:0] IMG_W_S = 16'(IMG_W);
    localparam logic [7:0]         MAX_K8  = 8'(MAX_K);

    state_t              state_r;
    logic [7:0]          cfg_k_r, cfg_n_r, cfg_p_r, out_w_r;
    logic [1:0]          cfg_s_r;
    logic [7:0]          n_r, oy_r, ox_r, ky_r, kx_r;
    logic [ACC_W-1:0]    acc_r;
    logic                tap_vld_r, tap_pad_r;
    logic                in_en_r, w_en_r, f_en_r;
    logic [15:0]         in_addr_r, w_addr_r, f_addr_r;
    logic [3:0]          f_we_r;
    logic [31:0]         f_din_r;
    logic                done_r, err_out_r, busy_r;

    logic [7:0]          cfg_k_s, cfg_n_s, cfg_p_s, p_in_s, k_m1_s, ow_m1_s;
    logic [1:0]          cfg_s_s;
    logic [15:0]         span_s, div_s, out_w_calc_s;
    logic                illegal_s, last_tap_s, last_pix_s;
    logic [7:0]          nt_n_s, nt_oy_s, nt_ox_s, nt_ky_s, nt_kx_s;
    logic signed [15:0]  iy_s, ix_s;
    logic                in_ok_s;
    logic [15:0]         in_idx_s, w_idx_s, f_idx_s, k16_s, ow16_s;
    logic [15:0]         in_addr_s, w_addr_s, f_addr_s;
    logic signed [2*DATA_W-1:0] prod_s;
    logic [ACC_W-1:0]    acc_add_s, acc_nxt_s;

    // Configuration view: live inputs while being checked, latched copy afterwards.
    always_comb begin
        p_in_s  = MODE_PADDING ? ((MODE_KERNEL_SIZE - 8'd1) >> 1) : 8'd0;
        cfg_k_s = (state_r == ST_CHECK) ? MODE_KERNEL_SIZE : cfg_k_r;
        cfg_n_s = (state_r == ST_CHECK) ? MODE_KERNEL_NUMS : cfg_n_r;
        cfg_s_s = (state_r == ST_CHECK) ? MODE_STRIDE      : cfg_s_r;
        cfg_p_s = (state_r == ST_CHECK) ? p_in_s           : cfg_p_r;
        k_m1_s  = cfg_k_s - 8'd1;
        ow_m1_s = out_w_r - 8'd1;
        span_s  = IMG_W16 + {7'd0, cfg_p_s, 1'b0} - {8'd0, cfg_k_s};
        illegal_s = (~cfg_k_s[0]) || (cfg_k_s > MAX_K8) || (cfg_n_s == 8'd0) ||
                    (cfg_s_s == 2'd0) ||
                    ({8'd0, cfg_k_s} > (IMG_W16 + {7'd0, cfg_p_s, 1'b0}));
        div_s        = (cfg_s_s == 2'd0) ? 16'd1 : {14'd0, cfg_s_s};
        out_w_calc_s = (span_s / div_s) + 16'd1;
        last_tap_s = (ky_r == k_m1_s) && (kx_r == k_m1_s);
        last_pix_s = (ox_r == ow_m1_s) && (oy_r == ow_m1_s) && (n_r == (cfg_n_r - 8'd1));
    end

    // Coordinates of the tap to be issued in the next cycle.
    always_comb begin
        nt_n_s  = n_r;
        nt_oy_s = oy_r;
        nt_ox_s = ox_r;
        nt_ky_s = ky_r;
        nt_kx_s = kx_r;
        case (state_r)
            ST_CHECK: begin
                nt_n_s  = 8'd0;
                nt_oy_s = 8'd0;
                nt_ox_s = 8'd0;
                nt_ky_s = 8'd0;
                nt_kx_s = 8'd0;
            end
            ST_ISSUE: begin
                if (kx_r == k_m1_s) begin
                    nt_kx_s = 8'd0;
                    nt_ky_s = ky_r + 8'd1;
                end else begin
                    nt_kx_s = kx_r + 8'd1;
                end
            end
            ST_WRITE: begin
                nt_ky_s = 8'd0;
                nt_kx_s = 8'd0;
                if (ox_r == ow_m1_s) begin
                    nt_ox_s = 8'd0;
                    if (oy_r == ow_m1_s) begin
                        nt_oy_s = 8'd0;
                        nt_n_s  = n_r + 8'd1;
                    end else begin
                        nt_oy_s = oy_r + 8'd1;
                    end
                end else begin
                    nt_ox_s = ox_r + 8'd1;
                end
            end
            default: begin
                nt_n_s = n_r;
            end
        endcase
    end

    // Address generation for the next tap and the current output pixel, plus the MAC.
    always_comb begin
        k16_s    = {8'd0, cfg_k_s};
        ow16_s   = {8'd0, out_w_r};
        iy_s     = $signed({8'd0, nt_oy_s}) * $signed({14'd0, cfg_s_s}) +
                   $signed({8'd0, nt_ky_s}) - $signed({8'd0, cfg_p_s});
        ix_s     = $signed({8'd0, nt_ox_s}) * $signed({14'd0, cfg_s_s}) +
                   $signed({8'd0, nt_kx_s}) - $signed({8'd0, cfg_p_s});
        in_ok_s  = (iy_s >= 16'sd0) && (iy_s < IMG_W_S) && (ix_s >= 16'sd0) && (ix_s < IMG_W_S);
        in_idx_s = iy_s * IMG_W_S + ix_s;
        w_idx_s  = {8'd0, nt_n_s} * k16_s * k16_s + {8'd0, nt_ky_s} * k16_s + {8'd0, nt_kx_s};
        f_idx_s  = {8'd0, n_r} * ow16_s * ow16_s + {8'd0, oy_r} * ow16_s + {8'd0, ox_r};
        in_addr_s = IN_BASE + (in_idx_s << 2);
        w_addr_s  = W_BASE + (w_idx_s << 2);
        f_addr_s  = F_BASE + (f_idx_s << 2);
        prod_s    = $signed(to_input_mem.dout[DATA_W-1:0]) * $signed(to_weight_mem.dout[DATA_W-1:0]);
        acc_add_s = (tap_vld_r && !tap_pad_r) ? ACC_W'(prod_s) : {ACC_W{1'b0}};
        acc_nxt_s = acc_r + acc_add_s;
    end

    // Main sequencer: state, counters, accumulator and all registered outputs.
    always_ff @(posedge clk_a or negedge arstz_aq) begin
        if (!arstz_aq) begin
            state_r   <= ST_IDLE;
            cfg_k_r   <= 8'd0;
            cfg_n_r   <= 8'd0;
            cfg_s_r   <= 2'd0;
            cfg_p_r   <= 8'd0;
            out_w_r   <= 8'd0;
            n_r       <= 8'd0;
            oy_r      <= 8'd0;
            ox_r      <= 8'd0;
            ky_r      <= 8'd0;
            kx_r      <= 8'd0;
            acc_r     <= {ACC_W{1'b0}};
            tap_vld_r <= 1'b0;
            tap_pad_r <= 1'b0;
            in_en_r   <= 1'b0;
            in_addr_r <= 16'd0;
            w_en_r    <= 1'b0;
            w_addr_r  <= 16'd0;
            f_en_r    <= 1'b0;
            f_we_r    <= 4'd0;
            f_addr_r  <= 16'd0;
            f_din_r   <= 32'd0;
            done_r    <= 1'b0;
            err_out_r <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            // Memory strobes are single-cycle unless re-armed below.
            in_en_r   <= 1'b0;
            in_addr_r <= 16'd0;
            w_en_r    <= 1'b0;
            w_addr_r  <= 16'd0;
            f_en_r    <= 1'b0;
            f_we_r    <= 4'd0;
            f_addr_r  <= 16'd0;
            f_din_r   <= 32'd0;
            done_r    <= 1'b0;
            err_out_r <= 1'b0;
            tap_vld_r <= 1'b0;
            tap_pad_r <= 1'b0;
            acc_r     <= acc_nxt_s;
            case (state_r)
                ST_IDLE: begin
                    if (CMD_START) begin
                        state_r <= ST_CHECK;
                        busy_r  <= 1'b1;
                    end else begin
                        busy_r  <= 1'b0;
                    end
                end
                ST_CHECK: begin
                    cfg_k_r <= cfg_k_s;
                    cfg_n_r <= cfg_n_s;
                    cfg_s_r <= cfg_s_s;
                    cfg_p_r <= cfg_p_s;
                    acc_r   <= {ACC_W{1'b0}};
                    if (illegal_s) begin
                        state_r   <= ST_DONE;
                        done_r    <= 1'b1;
                        err_out_r <= 1'b1;
                    end else begin
                        state_r   <= ST_ISSUE;
                        out_w_r   <= out_w_calc_s[7:0];
                        n_r       <= nt_n_s;
                        oy_r      <= nt_oy_s;
                        ox_r      <= nt_ox_s;
                        ky_r      <= nt_ky_s;
                        kx_r      <= nt_kx_s;
                        in_en_r   <= in_ok_s;
                        in_addr_r <= in_ok_s ? in_addr_s : 16'd0;
                        w_en_r    <= 1'b1;
                        w_addr_r  <= w_addr_s;
                    end
                end
                ST_ISSUE: begin
                    // Tap issued this cycle; its product lands one cycle later.
                    tap_vld_r <= 1'b1;
                    tap_pad_r <= ~in_en_r;
                    if (last_tap_s) begin
                        state_r <= ST_DRAIN;
                    end else begin
                        ky_r      <= nt_ky_s;
                        kx_r      <= nt_kx_s;
                        in_en_r   <= in_ok_s;
                        in_addr_r <= in_ok_s ? in_addr_s : 16'd0;
                        w_en_r    <= 1'b1;
                        w_addr_r  <= w_addr_s;
                    end
                end
                ST_DRAIN: begin
                    // acc_nxt_s already includes the final product of the pixel.
                    state_r  <= ST_WRITE;
                    f_en_r   <= 1'b1;
                    f_we_r   <= 4'b1111;
                    f_addr_r <= f_addr_s;
                    f_din_r  <= acc_nxt_s;
                end
                ST_WRITE: begin
                    acc_r <= {ACC_W{1'b0}};
                    if (last_pix_s) begin
                        state_r <= ST_DONE;
                        done_r  <= 1'b1;
                    end else begin
                        state_r   <= ST_ISSUE;
                        n_r       <= nt_n_s;
                        oy_r      <= nt_oy_s;
                        ox_r      <= nt_ox_s;
                        ky_r      <= nt_ky_s;
                        kx_r      <= nt_kx_s;
                        in_en_r   <= in_ok_s;
                        in_addr_r <= in_ok_s ? in_addr_s : 16'd0;
                        w_en_r    <= 1'b1;
                        w_addr_r  <= w_addr_s;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign to_input_mem.en     = in_en_r;
    assign to_input_mem.we     = 4'd0;
    assign to_input_mem.addr   = in_addr_r;
    assign to_input_mem.din    = 32'd0;
    assign to_weight_mem.en    = w_en_r;
    assign to_weight_mem.we    = 4'd0;
    assign to_weight_mem.addr  = w_addr_r;
    assign to_weight_mem.din   = 32'd0;
    assign to_feature_mem.en   = f_en_r;
    assign to_feature_mem.we   = f_we_r;
    assign to_feature_mem.addr = f_addr_r;
    assign to_feature_mem.din  = f_din_r;
    assign CMD_DONE            = done_r;
    assign CMD_DONE_VALID      = done_r;
    assign CMD_ERR             = err_out_r;
    assign BUSY                = busy_r;

endmodule

// File: doc/cnnip_conv_engine.md
# cnnip_conv_engine

Parametrised successor of the single-shot CNN IP controller. Performs a complete 2-D convolution directly out of the internal memories using one signed MAC. Supports configurable kernel size, kernel count, stride and same-padding, and writes one ACC_W result per output pixel per kernel into the feature memory. It sits between the configuration register block and the three internal memories (input, weight, feature); it keeps no image copy in registers.

## Interface
- IMG_W, 32, square input image side length (pixels)
- DATA_W, 16, signed input/weight width (low DATA_W bits of mem dout)
- ACC_W, 32, signed accumulator / feature word width
- MAX_K, 7, largest legal kernel side
- IN_BASE, 16'h1000, input mem byte base; word i at IN_BASE+4*i
- W_BASE, 16'h2000, weight mem byte base; word i at W_BASE+4*i
- F_BASE, 16'h3000, feature mem byte base; word i at F_BASE+4*i
- clk_a  in  1  clock
- arstz_aq  in  1  reset, asynchronous, active-low
- to_input_mem  cnnip_mem_if.master  -  read-only port, 1-cycle read latency
- to_weight_mem  cnnip_mem_if.master  -  read-only port, 1-cycle read latency
- to_feature_mem  cnnip_mem_if.master  -  write-only port
- CMD_START  in  1  start pulse, sampled only in IDLE
- MODE_KERNEL_SIZE  in  8  kernel side K
- MODE_KERNEL_NUMS  in  8  kernel count N
- MODE_STRIDE  in  2  stride S
- MODE_PADDING  in  1  1 = pad P=(K-1)/2 zeros per side, 0 = P=0
- CMD_DONE  out  1  one-cycle done pulse
- CMD_DONE_VALID  out  1  equal to CMD_DONE
- CMD_ERR  out  1  high with CMD_DONE when configuration was illegal
- BUSY  out  1  high in every state except IDLE

## Operation
- States: IDLE, CHECK, ISSUE, DRAIN, WRITE, DONE.
- IDLE: CMD_START=1 -> CHECK. CMD_START in any other state is ignored.
- CHECK (1 cycle): latch K, N, S, P. Illegal if K=0, K even, K>MAX_K, N=0, S=0, or K>IMG_W+2P. Illegal -> DONE with err flag set. Legal -> clear counters (kernel n, oy, ox, ky, kx) and acc -> ISSUE.
- OUT_W = (IMG_W+2P-K)/S+1 (integer division). Total outputs = N*OUT_W*OUT_W.
- ISSUE (K*K cycles per pixel): one tap per cycle, kx innermost, then ky.
  - iy=oy*S+ky-P, ix=ox*S+kx-P.
  - In-range tap: input en=1, addr=IN_BASE+4*(iy*IMG_W+ix).
  - Out-of-range (pad) tap: input en=0; product forced to 0.
  - Weight en=1 on every tap, addr=W_BASE+4*(n*K*K+ky*K+kx).
  - we=0 and din=0 on both read ports.
- Pipeline: a registered valid/pad flag follows each issued tap. One cycle later, acc += signed(x)*signed(w), sign-extended to ACC_W. Overflow wraps modulo 2^ACC_W.
- After the last tap -> DRAIN (1 cycle, final product accumulates) -> WRITE.
- WRITE (1 cycle): feature en=1, we=4'b1111, addr=F_BASE+4*(n*OUT_W*OUT_W+oy*OUT_W+ox), din=acc. Then clear acc and advance ox, then oy, then n.
  - More outputs remain -> ISSUE.
  - Last output -> DONE.
- DONE (1 cycle): CMD_DONE=CMD_DONE_VALID=1, CMD_ERR=err flag -> IDLE.
- Config inputs are not re-read after CHECK; changes mid-run have no effect.
- Memory enables are low in IDLE, CHECK and DONE. Feature en is high only in WRITE.

## Timing
- Reset values: state IDLE; CMD_DONE, CMD_DONE_VALID, CMD_ERR, BUSY = 0; all mem en/we/addr/din = 0; counters and acc = 0.
- Reset mid-operation: immediate return to IDLE and all enables low. A partially computed pixel is not written.
- CMD_START at cycle 0 -> CHECK at cycle 1 -> first ISSUE at cycle 2.
- Each output costs K*K+2 cycles.
- DONE occurs at cycle 2+N*OUT_W²*(K*K+2). Error DONE occurs at cycle 2.
- CMD_DONE is exactly one cycle wide. BUSY falls in the cycle after DONE.
- A new CMD_START is accepted at the earliest in the cycle after DONE.

## Test plan
- IMG_W=8, K=3, N=1, S=1, P=0, all inputs 1, all weights 1 -> 36 writes of 9 at F_BASE..F_BASE+0x8C; DONE at cycle 398.
- IMG_W=8, K=3, padding on, all ones -> 64 writes: corners 4, edges 6, interior 9; no input read with en=1 outside the image.
- IMG_W=8, K=3, S=2, P=0, input[i]=i, weight centre tap=1 and others 0 -> 9 writes (OUT_W=3), values 9,11,13,25,27,29,41,43,45.
- N=2, weights kernel0 all 1, kernel1 all -1, inputs 2 -> first 36 words = 18, next 36 = -18 (0xFFFFFFEE).
- Illegal configs (K=4; N=0; S=0) -> CMD_DONE and CMD_ERR high at cycle 2; zero feature writes.
- Assert arstz_aq low mid-ISSUE, then restart with legal config -> no stray write; second run output matches the golden model.
